// File: rtl/mips_alu_arbiter.sv
// Round-robin arbiter sharing one ALU (control decoder + datapath) between two requesters.
// One operation in flight; result returned to the winner after a fixed ALU latency.
module mips_alu_arbiter #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [2:0]       req_alu_op0,
  input  logic [2:0]       req_alu_op1,
  input  logic [2:0]       req_func0,
  input  logic [2:0]       req_func1,
  input  logic [WIDTH-1:0] req_a0,
  input  logic [WIDTH-1:0] req_b0,
  input  logic [WIDTH-1:0] req_a1,
  input  logic [WIDTH-1:0] req_b1,
  output logic [1:0]       req_ready,
  output logic [1:0]       resp_valid,
  output logic [WIDTH-1:0] resp_result,
  output logic             resp_zero,
  output logic [2:0]       alu_op_o,
  output logic [2:0]       func_o,
  output logic [WIDTH-1:0] alu_a_o,
  output logic [WIDTH-1:0] alu_b_o,
  input  logic [WIDTH-1:0] alu_result_i,
  input  logic             alu_zero_i,
  output logic             busy
);
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                     state;
  logic                       owner;
  logic                       last_grant;
  logic [CW-1:0]              cnt;
  logic                       win;
  logic [1:0][2:0]            op_v, fn_v;
  logic [1:0][WIDTH-1:0]      a_v, b_v;

  assign op_v = {req_alu_op1, req_alu_op0};
  assign fn_v = {req_func1, req_func0};
  assign a_v  = {req_a1, req_a0};
  assign b_v  = {req_b1, req_b0};

  // A lone requester always wins; a tie goes to whoever was not served last.
  always_comb begin
    win = ~last_grant;
    if (req_valid == 2'b01)      win = 1'b0;
    else if (req_valid == 2'b10) win = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      cnt         <= '0;
      req_ready   <= 2'b00;
      resp_valid  <= 2'b00;
      resp_result <= '0;
      resp_zero   <= 1'b0;
      alu_op_o    <= 3'b000;
      func_o      <= 3'b000;
      alu_a_o     <= '0;
      alu_b_o     <= '0;
      busy        <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|req_valid) begin
          owner      <= win;
          last_grant <= win;
          alu_op_o   <= op_v[win];
          func_o     <= fn_v[win];
          alu_a_o    <= a_v[win];
          alu_b_o    <= b_v[win];
          req_ready  <= win ? 2'b10 : 2'b01;
          busy       <= 1'b1;
          state      <= ISSUE;
        end
        ISSUE: begin
          req_ready <= 2'b00;
          cnt       <= CW'(LATENCY - 1);
          state     <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          resp_result <= alu_result_i;
          resp_zero   <= alu_zero_i;
          resp_valid  <= owner ? 2'b10 : 2'b01;
          state       <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: begin
          resp_valid <= 2'b00;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mips_alu_arbiter.sv
// Bench for mips_alu_arbiter: directed vector table, corner sequences, and a random
// phase checked against a transaction-timeline model (LATENCY=1 and LATENCY=3 builds).
module tb_mips_alu_arbiter;
  localparam int L1 = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // LATENCY=1 instance
  logic [1:0]  req_valid = '0;
  logic [2:0]  req_alu_op0 = '0, req_alu_op1 = '0, req_func0 = '0, req_func1 = '0;
  logic [31:0] req_a0 = '0, req_b0 = '0, req_a1 = '0, req_b1 = '0;
  logic [1:0]  req_ready, resp_valid;
  logic [31:0] resp_result, alu_a_o, alu_b_o, alu_res;
  logic        resp_zero, busy, alu_zero;
  logic [2:0]  alu_op_o, func_o;
  logic        zmode = 1'b0;

  // LATENCY=3 instance
  logic [1:0]  req_valid_3 = '0;
  logic [31:0] req_a_3 = 32'h11, req_b_3 = 32'h22;
  logic [1:0]  req_ready_3, resp_valid_3;
  logic [31:0] resp_result_3, alu_a_3, alu_b_3;
  logic        resp_zero_3, busy_3;
  logic [2:0]  alu_op_3, func_3;
  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] alu_fn(logic [2:0] op, logic [2:0] f, logic [31:0] a, logic [31:0] b);
    case (op)
      3'b010:  return a + b;
      3'b110:  return a - b;
      default: return a ^ b ^ {29'd0, f};
    endcase
  endfunction

  assign alu_res  = zmode ? 32'd0 : alu_fn(alu_op_o, func_o, alu_a_o, alu_b_o);
  assign alu_zero = (alu_res == 32'd0);

  mips_alu_arbiter #(.WIDTH(32), .LATENCY(L1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid),
    .req_alu_op0(req_alu_op0), .req_alu_op1(req_alu_op1),
    .req_func0(req_func0), .req_func1(req_func1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_result(resp_result),
    .resp_zero(resp_zero), .alu_op_o(alu_op_o), .func_o(func_o),
    .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_result_i(alu_res),
    .alu_zero_i(alu_zero), .busy(busy));

  mips_alu_arbiter #(.WIDTH(32), .LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_3),
    .req_alu_op0(3'b010), .req_alu_op1(3'b010),
    .req_func0(3'b000), .req_func1(3'b000),
    .req_a0(req_a_3), .req_b0(req_b_3), .req_a1(req_a_3), .req_b1(req_b_3),
    .req_ready(req_ready_3), .resp_valid(resp_valid_3), .resp_result(resp_result_3),
    .resp_zero(resp_zero_3), .alu_op_o(alu_op_3), .func_o(func_3),
    .alu_a_o(alu_a_3), .alu_b_o(alu_b_3), .alu_result_i(cyc),
    .alu_zero_i(cyc[0]), .busy(busy_3));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req_valid = 2'b00;
    req_valid_3 = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        sel;
    logic [2:0]  op, fn;
    logic [31:0] a, b, res;
    logic        z;
  } vec_t;

  task automatic drive(input logic sel, input logic [2:0] op, input logic [2:0] fn,
                       input logic [31:0] a, input logic [31:0] b);
    if (sel) begin
      req_alu_op1 = op; req_func1 = fn; req_a1 = a; req_b1 = b; req_valid = 2'b10;
    end else begin
      req_alu_op0 = op; req_func0 = fn; req_a0 = a; req_b0 = b; req_valid = 2'b01;
    end
  endtask

  // Single request from idle: ready 1 cycle after capture, response 2 cycles later.
  task automatic run_single(input vec_t v);
    int n;
    logic [1:0] oh;
    oh = v.sel ? 2'b10 : 2'b01;
    @(negedge clk);
    drive(v.sel, v.op, v.fn, v.a, v.b);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (req_ready == 2'b00 && n < 8);
    chk("ready_latency", n, 1);
    chk("ready_vec", req_ready, oh);
    chk("alu_op_o", alu_op_o, v.op);
    chk("func_o", func_o, v.fn);
    chk("alu_a_o", alu_a_o, v.a);
    chk("alu_b_o", alu_b_o, v.b);
    req_valid = 2'b00;
    @(negedge clk);
    chk("wait_resp", resp_valid, 2'b00);
    chk("wait_busy", busy, 1'b1);
    @(negedge clk);
    chk("resp_vec", resp_valid, oh);
    chk("resp_result", resp_result, v.res);
    chk("resp_zero", resp_zero, v.z);
    @(negedge clk);
    chk("idle_busy", busy, 1'b0);
    chk("idle_resp", resp_valid, 2'b00);
  endtask

  initial begin
    vec_t tbl[5];
    logic [31:0] c0, tmp;
    logic [1:0]  pend, e_ready, e_resp;
    logic [2:0]  p_op[2], p_fn[2], c_op, c_fn;
    logic [31:0] p_a[2], p_b[2], c_a, c_b, e_res;
    logic        m_owner, m_last, e_zero, e_busy;
    int          ph;

    tbl[0] = '{1'b0, 3'b010, 3'b000, 32'd5, 32'd7, 32'd12, 1'b0};
    tbl[1] = '{1'b1, 3'b110, 3'b000, 32'd9, 32'd9, 32'd0, 1'b1};
    tbl[2] = '{1'b0, 3'b110, 3'b000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0};
    tbl[3] = '{1'b1, 3'b000, 3'b101, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_FFFA, 1'b0};
    tbl[4] = '{1'b0, 3'b001, 3'b111, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 32'd7, 1'b0};

    do_reset();
    @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_resp", resp_valid, 2'b00);
    chk("rst_result", resp_result, 32'd0);
    chk("rst_zero", resp_zero, 1'b0);
    chk("rst_op", {alu_op_o, func_o}, 6'd0);
    chk("rst_ab", {alu_a_o, alu_b_o}, 64'd0);
    chk("rst_busy", busy, 1'b0);

    for (int i = 0; i < 5; i++) run_single(tbl[i]);

    // Pass-through with an ALU reporting result 0 / zero 1
    zmode = 1'b1;
    run_single('{1'b1, 3'b000, 3'b101, 32'hFFFF_0000, 32'h0000_FFFF, 32'd0, 1'b1});
    zmode = 1'b0;

    // Both requesters held valid: grants alternate, 4 cycles per operation
    do_reset();
    req_alu_op0 = 3'b010; req_func0 = 3'b000; req_a0 = 32'd1; req_b0 = 32'd1;
    req_alu_op1 = 3'b010; req_func1 = 3'b000; req_a1 = 32'd3; req_b1 = 32'd4;
    req_valid = 2'b11;
    for (int k = 1; k <= 16; k++) begin
      logic [1:0] oh;
      @(negedge clk);
      oh = (((k - 1) / 4) % 2 == 0) ? 2'b01 : 2'b10;
      chk($sformatf("alt_ready_%0d", k), req_ready, (k % 4 == 1) ? oh : 2'b00);
      chk($sformatf("alt_resp_%0d", k), resp_valid, (k % 4 == 3) ? oh : 2'b00);
      if (k % 4 == 3) chk($sformatf("alt_result_%0d", k), resp_result, (oh == 2'b01) ? 32'd2 : 32'd7);
    end
    req_valid = 2'b00;

    // Late request from requester 1 during requester 0's WAIT
    do_reset();
    @(negedge clk);
    drive(1'b0, 3'b010, 3'b000, 32'd10, 32'd20);
    @(negedge clk);
    chk("late_r0_ready", req_ready, 2'b01);
    req_valid = 2'b00;
    @(negedge clk);
    req_alu_op1 = 3'b010; req_func1 = 3'b000; req_a1 = 32'd3; req_b1 = 32'd4;
    req_valid = 2'b10;
    @(negedge clk);
    chk("late_resp0", resp_valid, 2'b01);
    chk("late_result0", resp_result, 32'd30);
    chk("late_no_ready_resp", req_ready, 2'b00);
    @(negedge clk);
    chk("late_no_ready_idle", req_ready, 2'b00);
    chk("late_idle_busy", busy, 1'b0);
    @(negedge clk);
    chk("late_r1_ready", req_ready, 2'b10);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    chk("late_result1", resp_result, 32'd7);

    // LATENCY=3: result is the ALU value in the third WAIT cycle
    @(negedge clk);
    c0 = cyc;
    req_valid_3 = 2'b01;
    @(negedge clk);
    chk("l3_ready", req_ready_3, 2'b01);
    req_valid_3 = 2'b00;
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("l3_resp_%0d", k), resp_valid_3, (k == 5) ? 2'b01 : 2'b00);
    end
    tmp = c0 + 32'd4;
    chk("l3_result", resp_result_3, tmp);
    chk("l3_zero", resp_zero_3, tmp[0]);
    @(negedge clk);
    chk("l3_idle_busy", busy_3, 1'b0);

    // Asynchronous reset while in WAIT
    @(negedge clk);
    drive(1'b1, 3'b010, 3'b000, 32'd8, 32'd9);
    @(negedge clk);
    chk("rw_ready", req_ready, 2'b10);
    req_valid = 2'b00;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rw_busy", busy, 1'b0);
    chk("rw_result", resp_result, 32'd0);
    chk("rw_ab", {alu_a_o, alu_b_o}, 64'd0);
    chk("rw_opfn", {alu_op_o, func_o}, 6'd0);
    chk("rw_ready0", req_ready, 2'b00);
    begin
      int seen = 0;
      repeat (2) begin
        @(negedge clk);
        if (resp_valid != 2'b00) seen++;
      end
      rst_n = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (resp_valid != 2'b00) seen++;
      end
      chk("rw_no_resp", seen, 0);
    end
    req_a0 = 32'd1; req_b0 = 32'd1; req_a1 = 32'd3; req_b1 = 32'd4;
    req_alu_op0 = 3'b010; req_alu_op1 = 3'b010;
    req_valid = 2'b11;
    @(negedge clk);
    chk("rw_first_winner", req_ready, 2'b01);
    req_valid = 2'b00;

    // Random traffic against a timeline model: op lasts 3+L cycles from capture edge
    do_reset();
    pend = 2'b00; e_ready = 2'b00; e_resp = 2'b00; e_res = '0; e_zero = 1'b0; e_busy = 1'b0;
    c_op = '0; c_fn = '0; c_a = '0; c_b = '0; m_last = 1'b1; m_owner = 1'b0; ph = -1;
    for (int t = 0; t < 400; t++) begin
      chk("rnd_ready", req_ready, e_ready);
      chk("rnd_resp", resp_valid, e_resp);
      chk("rnd_busy", busy, e_busy);
      chk("rnd_result", {resp_zero, resp_result}, {e_zero, e_res});
      chk("rnd_alu_ports", {alu_op_o, func_o, alu_a_o, alu_b_o}, {c_op, c_fn, c_a, c_b});
      for (int i = 0; i < 2; i++) begin
        if (e_ready[i]) pend[i] = 1'b0;
        if (!pend[i] && $urandom_range(0, 2) == 0) begin
          pend[i] = 1'b1;
          p_op[i] = 3'($urandom_range(0, 7));
          p_fn[i] = 3'($urandom_range(0, 7));
          p_a[i]  = $urandom;
          p_b[i]  = ($urandom_range(0, 3) == 0) ? p_a[i] : $urandom;
        end
      end
      req_valid = pend;
      req_alu_op0 = p_op[0]; req_func0 = p_fn[0]; req_a0 = p_a[0]; req_b0 = p_b[0];
      req_alu_op1 = p_op[1]; req_func1 = p_fn[1]; req_a1 = p_a[1]; req_b1 = p_b[1];
      e_ready = 2'b00;
      e_resp  = 2'b00;
      if (ph < 0) begin
        if (pend != 2'b00) begin
          m_owner = (pend == 2'b11) ? ~m_last : pend[1];
          m_last  = m_owner;
          c_op = p_op[m_owner]; c_fn = p_fn[m_owner]; c_a = p_a[m_owner]; c_b = p_b[m_owner];
          ph = 0;
          e_ready[m_owner] = 1'b1;
          e_busy = 1'b1;
        end
      end else begin
        ph++;
        if (ph == L1 + 1) begin
          e_resp[m_owner] = 1'b1;
          e_res  = alu_fn(c_op, c_fn, c_a, c_b);
          e_zero = (e_res == 32'd0);
        end else if (ph == L1 + 2) begin
          e_busy = 1'b0;
          ph = -1;
        end
      end
      @(negedge clk);
    end
    req_valid = 2'b00;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
